// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/SLT through EXEC, optional
// WIDTH-cycle shift-add MULU through MUL when ALU_MUL_EN is defined.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             overflow,
   output logic             zero
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
   logic             overflow_q, overflow_d, zero_q, zero_d, done_q, done_d;

   logic             is_sub, c_msb_in, ovf_as;
   logic [WIDTH-1:0] b_eff, alu_res;
   logic [WIDTH:0]   sum_ext;
   logic             alu_ovf;

   // SLT shares the subtract path; its sign bit corrected by overflow gives a<b.
   always_comb begin
      is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
      b_eff    = is_sub ? ~b_q : b_q;
      sum_ext  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      c_msb_in = a_q[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
      ovf_as   = c_msb_in ^ sum_ext[WIDTH];
      alu_res  = '0;
      alu_ovf  = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_ovf = ovf_as;
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_NOR: alu_res = ~(a_q | b_q);
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ ovf_as};
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   // Multiplier sits in the low half of the accumulator and shifts out LSB first.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
   end
`endif

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      done_d      = 1'b0;
`ifdef ALU_MUL_EN
      acc_d       = acc_q;
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               state_d = S_EXEC;
`ifdef ALU_MUL_EN
               acc_d = {{WIDTH{1'b0}}, b};
               cnt_d = '0;
               if (op == OP_MUL) state_d = S_MUL;
`endif
            end
         end
         S_EXEC: begin
            result_d    = alu_res;
            result_hi_d = '0;
            overflow_d  = alu_ovf;
            zero_d      = (alu_res == '0);
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               result_d    = acc_step[WIDTH-1:0];
               result_hi_d = acc_step[2*WIDTH-1:WIDTH];
               overflow_d  = (acc_step[2*WIDTH-1:WIDTH] != '0);
               zero_d      = (acc_step[WIDTH-1:0] == '0);
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef ALU_MUL_EN
         acc_q       <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         done_q      <= done_d;
`ifdef ALU_MUL_EN
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); MULU checks follow the ALU_MUL_EN build.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, overflow, zero;
   logic [31:0] result, result_hi;

   int n_asserts = 0;
   int n_fail    = 0;
   int lat;
   bit found;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .result_hi(result_hi),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s failed", tag);
      end
   endtask

   // Counts negedges after acceptance until done is seen; lat is cycles after accept.
   task automatic wait_done(input int lat_in, output int lat_out, output bit seen);
      lat_out = lat_in;
      seen    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         lat_out++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~x; b = ~y;
      wait_done(0, lat, found);
      chk({tag, "_done_seen"}, 64'(found), 64'd1);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] r, input logic [31:0] rh,
                          input logic ov, input logic z, input int exp_lat);
      chk({tag, "_result"},    64'(result),    64'(r));
      chk({tag, "_result_hi"}, 64'(result_hi), 64'(rh));
      chk({tag, "_overflow"},  64'(overflow),  64'(ov));
      chk({tag, "_zero"},      64'(zero),      64'(z));
      chk({tag, "_latency"},   64'(lat),       64'(exp_lat));
      chk({tag, "_busy_low"},  64'(busy),      64'd0);
   endtask

   logic [2:0]  b2b_op[4]  = '{3'b010, 3'b011, 3'b100, 3'b101};
   logic [31:0] b2b_exp[4] = '{32'd80, 32'd1783, 32'd1703, 32'hFFFFF908};

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_result_hi", 64'(result_hi), 64'd0);
      chk("rst_ovf_zero", {62'd0, overflow, zero}, 64'd0);
      rst_n = 1'b1;

      run_op("sub", 3'b001, 32'd54565, 32'd4565);
      chk_out("sub", 32'd50000, 32'd0, 1'b0, 1'b0, 1);
      @(negedge clk);
      chk("sub_done_one_cycle", 64'(done), 64'd0);

      // Back-to-back with start held high: each op is taken in its predecessor's done cycle.
      @(negedge clk);
      start = 1'b1; a = 32'd1265; b = 32'd598; op = b2b_op[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d_busy", i), {62'd0, busy, done}, 64'd2);
         @(negedge clk);
         chk($sformatf("b2b%0d_done", i), {62'd0, busy, done}, 64'd1);
         chk($sformatf("b2b%0d_result", i), 64'(result), 64'(b2b_exp[i]));
         if (i < 3) op = b2b_op[i+1];
         else start = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      chk("b2b_no_extra_done", 64'(done), 64'd0);

      run_op("add_ovf", 3'b000, 32'h7FFFFFFF, 32'd1);
      chk_out("add_ovf", 32'h80000000, 32'd0, 1'b1, 1'b0, 1);
      run_op("sub_ovf", 3'b001, 32'h80000000, 32'd1);
      chk_out("sub_ovf", 32'h7FFFFFFF, 32'd0, 1'b1, 1'b0, 1);

      run_op("slt_lt", 3'b110, 32'd666, 32'd7777);
      chk_out("slt_lt", 32'd1, 32'd0, 1'b0, 1'b0, 1);
      run_op("slt_eq", 3'b110, 32'd55, 32'd55);
      chk_out("slt_eq", 32'd0, 32'd0, 1'b0, 1'b1, 1);
      run_op("slt_minneg", 3'b110, 32'h80000000, 32'd1);
      chk_out("slt_minneg", 32'd1, 32'd0, 1'b0, 1'b0, 1);
      run_op("slt_pos", 3'b110, 32'd1, 32'h80000000);
      chk_out("slt_pos", 32'd0, 32'd0, 1'b0, 1'b1, 1);

      run_op("add_pre", 3'b000, 32'd7, 32'd8);
      chk_out("add_pre", 32'd15, 32'd0, 1'b0, 1'b0, 1);

`ifdef ALU_MUL_EN
      @(negedge clk);
      op = 3'b111; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = 32'd3; b = 32'd3;
      repeat (3) @(negedge clk);
      op = 3'b000; a = 32'd1; b = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mul_busy_ignore", {62'd0, busy, done}, 64'd2);
      chk("mul_hold_result", 64'(result), 64'd15);
      wait_done(4, lat, found);
      chk("mul_big_done_seen", 64'(found), 64'd1);
      chk_out("mul_big", 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 32);
      @(negedge clk);
      chk("mul_big_no_queue", {62'd0, busy, done}, 64'd0);
      chk("mul_big_hold", 64'(result_hi), 64'hFFFFFFFE);

      run_op("mul_3x5", 3'b111, 32'd3, 32'd5);
      chk_out("mul_3x5", 32'd15, 32'd0, 1'b0, 1'b0, 32);

      // Abort a MULU ten cycles in.
      @(negedge clk);
      op = 3'b111; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      chk("abort_no_early_done", 64'(found), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_flags", {60'd0, busy, done, overflow, zero}, 64'd0);
`else
      run_op("mul_off", 3'b111, 32'd3, 32'd5);
      chk_out("mul_off", 32'd0, 32'd0, 1'b0, 1'b1, 1);
      run_op("add_pre2", 3'b000, 32'd7, 32'd8);
      chk_out("add_pre2", 32'd15, 32'd0, 1'b0, 1'b0, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_flags", {60'd0, busy, done, overflow, zero}, 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      found = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      chk("abort_no_done", 64'(found), 64'd0);

      run_op("add_after_rst", 3'b000, 32'd2, 32'd3);
      chk_out("add_after_rst", 32'd5, 32'd0, 1'b0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
